// File: rtl/register_file.sv
// register_file: 32 x 32-bit RV32I integer register file.
// Two combinational read ports with write-through bypass, one synchronous
// write port, x0 hardwired to zero, asynchronous active-low clear.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // A write is only effective when enabled and not targeting x0.
  logic wr_hit;
  assign wr_hit = reg_write && (rd != '0);

  // Next-state for the array: copy current contents, apply the single write,
  // and keep x0 pinned at zero so it can never hold a non-zero value.
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[rd] = write_data;
    end
    regs_d[0] = '0;
  end

  // Register storage; reset clears every entry without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: zero for x0 or while in reset, bypass a pending write,
  // otherwise the stored value.
  always_comb begin
    read_data1 = '0;
    if (reset && (rs1 != '0)) begin
      if (wr_hit && (rd == rs1)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[rs1];
      end
    end
  end

  // Read port 2: same behaviour as port 1, independently indexed.
  always_comb begin
    read_data2 = '0;
    if (reset && (rs2 != '0)) begin
      if (wr_hit && (rd == rs2)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[rs2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
// Inputs change on the falling edge; outputs are sampled 1ns after an input
// change (combinational read / bypass) or 1ns after a rising edge (stored).
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          reg_write;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl [32];
  logic [DW-1:0] e1, e2;
  int checks = 0;
  int errors = 0;

  // Reference view of one read port given the bench's own driven inputs.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    if (!reset || idx == '0) return '0;
    if (reg_write && rd != '0 && rd == idx) return write_data;
    return mdl[idx];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endfunction

  // Push the expected pair for the current inputs.
  function automatic void push_exp();
    exp_q.push_back(model_read(rs1));
    exp_q.push_back(model_read(rs2));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] d_rd,
                       input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    @(negedge clk);
    reg_write  = we;
    rd         = d_rd;
    write_data = wd;
    rs1        = a1;
    rs2        = a2;
  endtask

  // One rising edge; the model commits the write the DUT should have taken.
  task automatic tick();
    @(posedge clk);
    if (reset && reg_write && rd != '0) mdl[rd] = write_data;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; reg_write = 1'b0; rd = '0; write_data = '0;
    rs1 = 5'd5; rs2 = 5'd10;
    model_clear();
    #2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL reset_rd1 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL reset_rd2 got %h exp %h", read_data2, e2); end
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    push_exp();
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1 || e1 !== 32'h0) begin errors++; $display("FAIL post_reset_rd1 got %h exp %h", read_data1, 32'h0); end
    if (read_data2 !== e2 || e2 !== 32'h0) begin errors++; $display("FAIL post_reset_rd2 got %h exp %h", read_data2, 32'h0); end
  endtask

  task automatic test_write_readback();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd10, 32'hCAFEBABE, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd10); #1;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hCAFEBABE);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL readback_x5 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL readback_x10 got %h exp %h", read_data2, e2); end
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0); #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0); #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    // Compare the "during" pair is already in the queue; re-sample order is
    // preserved, so pop both pairs against what is observed now and earlier.
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL x0_rd1 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL x0_rd2 got %h exp %h", read_data2, e2); end
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
  endtask

  task automatic test_x0_during();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0); #1;
    exp_q.push_back(32'h0);
    e1 = exp_q.pop_front();
    checks++;
    if (read_data1 !== e1) begin errors++; $display("FAIL x0_during got %h exp %h", read_data1, e1); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7); #1;
    exp_q.push_back(32'h22222222); exp_q.push_back(32'h22222222);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL bypass_rd1 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL bypass_rd2 got %h exp %h", read_data2, e2); end
    tick();
    drive(1'b0, 5'd7, 32'h33333333, 5'd7, 5'd0); #1;
    exp_q.push_back(32'h22222222);
    e1 = exp_q.pop_front();
    checks++;
    if (read_data1 !== e1) begin errors++; $display("FAIL bypass_after got %h exp %h", read_data1, e1); end
  endtask

  task automatic test_disabled_write();
    drive(1'b0, 5'd5, 32'h12345678, 5'd5, 5'd10); tick();
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hCAFEBABE);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL disabled_x5 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL disabled_x10 got %h exp %h", read_data2, e2); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd9, 32'hAAAA0001, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd9, 32'hBBBB0002, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9); #1;
    exp_q.push_back(32'hBBBB0002); exp_q.push_back(32'hBBBB0002);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL last_wins_rd1 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL last_wins_rd2 got %h exp %h", read_data2, e2); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom(),
            5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
      if ($urandom_range(3, 0) == 0) rs1 = rd;
      #1;
      push_exp();
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks += 2;
      if (read_data1 !== e1) begin errors++; $display("FAIL rand_rd1 n=%0d rs1=%0d got %h exp %h", n, rs1, read_data1, e1); end
      if (read_data2 !== e2) begin errors++; $display("FAIL rand_rd2 n=%0d rs2=%0d got %h exp %h", n, rs2, read_data2, e2); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0); #1;
    exp_q.push_back(32'hDEADBEEF);
    e1 = exp_q.pop_front();
    checks++;
    if (read_data1 !== e1) begin errors++; $display("FAIL pre_async_x5 got %h exp %h", read_data1, e1); end
    // Pull reset low mid-cycle with a write to x5 pending; it must be lost.
    #1;
    reset = 1'b0; reg_write = 1'b1; rd = 5'd5; write_data = 32'h55555555; rs2 = 5'd5;
    model_clear();
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks += 2;
    if (read_data1 !== e1) begin errors++; $display("FAIL async_drop_rd1 got %h exp %h", read_data1, e1); end
    if (read_data2 !== e2) begin errors++; $display("FAIL async_drop_rd2 got %h exp %h", read_data2, e2); end
    tick();
    @(negedge clk);
    reg_write = 1'b0;
    reset = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    e1 = exp_q.pop_front();
    checks++;
    if (read_data1 !== e1) begin errors++; $display("FAIL async_after_x5 got %h exp %h", read_data1, e1); end
    // First write after release must take effect on the very next edge.
    drive(1'b1, 5'd5, 32'h0BADF00D, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0); #1;
    exp_q.push_back(32'h0BADF00D);
    e1 = exp_q.pop_front();
    checks++;
    if (read_data1 !== e1) begin errors++; $display("FAIL first_write_after_reset got %h exp %h", read_data1, e1); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_readback();
    test_x0_during();
    test_x0();
    test_bypass();
    test_disabled_write();
    test_back_to_back();
    test_random();
    test_async_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
